// File: rtl/fb_fill_ctrl.sv
// Frame-buffer fill sequencer: power-on clear, white clears and clipped SIZE x SIZE paints, one write per cycle.
// First write one cycle after the request edge; requests outside IDLE are dropped, never queued.
module fb_fill_ctrl #(
    parameter int W_RES = 640,
    parameter int H_RES = 480,
    parameter int SIZE  = 8
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        clear_req,
    input  logic        paint_req,
    input  logic [10:0] paint_x,
    input  logic [10:0] paint_y,
    input  logic [7:0]  paint_r,
    input  logic [7:0]  paint_g,
    input  logic [7:0]  paint_b,
    output logic        ready,
    output logic        done,
    output logic        write_enable,
    output logic [10:0] data_in_x,
    output logic [10:0] data_in_y,
    output logic [7:0]  red_data_in,
    output logic [7:0]  green_data_in,
    output logic [7:0]  blue_data_in
);

    typedef enum logic [2:0] {
        BOOT,
        IDLE,
        CLEAR,
        PAINT,
        DONE
    } state_t;

    localparam logic [11:0] X_LAST_W = 12'(W_RES - 1);
    localparam logic [11:0] Y_LAST_W = 12'(H_RES - 1);
    localparam logic [11:0] SPAN     = 12'(SIZE - 1);
    localparam logic [10:0] X_LAST   = 11'(W_RES - 1);
    localparam logic [10:0] Y_LAST   = 11'(H_RES - 1);

    state_t      state;
    logic [10:0] x_start;
    logic [10:0] x_end;
    logic [10:0] y_end;

    logic [11:0] px_far;
    logic [11:0] py_far;
    logic [10:0] px_end;
    logic [10:0] py_end;
    logic        off_screen;

    // Square end points at 12 bits so a start near 2047 cannot wrap past the clip.
    always_comb begin
        px_far     = {1'b0, paint_x} + SPAN;
        py_far     = {1'b0, paint_y} + SPAN;
        px_end     = (px_far > X_LAST_W) ? X_LAST : px_far[10:0];
        py_end     = (py_far > Y_LAST_W) ? Y_LAST : py_far[10:0];
        off_screen = ({1'b0, paint_x} > X_LAST_W) || ({1'b0, paint_y} > Y_LAST_W);
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state         <= BOOT;
            ready         <= 1'b0;
            done          <= 1'b0;
            write_enable  <= 1'b0;
            data_in_x     <= '0;
            data_in_y     <= '0;
            red_data_in   <= '0;
            green_data_in <= '0;
            blue_data_in  <= '0;
            x_start       <= '0;
            x_end         <= '0;
            y_end         <= '0;
        end else begin
            case (state)
                BOOT, IDLE: begin
                    if (state == BOOT || clear_req) begin
                        state         <= CLEAR;
                        ready         <= 1'b0;
                        write_enable  <= 1'b1;
                        data_in_x     <= '0;
                        data_in_y     <= '0;
                        red_data_in   <= 8'hFF;
                        green_data_in <= 8'hFF;
                        blue_data_in  <= 8'hFF;
                        x_start       <= '0;
                        x_end         <= X_LAST;
                        y_end         <= Y_LAST;
                    end else if (paint_req) begin
                        ready <= 1'b0;
                        if (off_screen) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state         <= PAINT;
                            write_enable  <= 1'b1;
                            data_in_x     <= paint_x;
                            data_in_y     <= paint_y;
                            red_data_in   <= paint_r;
                            green_data_in <= paint_g;
                            blue_data_in  <= paint_b;
                            x_start       <= paint_x;
                            x_end         <= px_end;
                            y_end         <= py_end;
                        end
                    end
                end
                // CLEAR and PAINT share the same row-major sweep over the latched window.
                CLEAR, PAINT: begin
                    if (data_in_x == x_end) begin
                        if (data_in_y == y_end) begin
                            state        <= DONE;
                            write_enable <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            data_in_x <= x_start;
                            data_in_y <= data_in_y + 11'd1;
                        end
                    end else begin
                        data_in_x <= data_in_x + 11'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state        <= BOOT;
                    ready        <= 1'b0;
                    done         <= 1'b0;
                    write_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_fill_ctrl.sv
// Bench for fb_fill_ctrl on a reduced 40x30 screen: vector table, random requests and reset corner cases.
module tb_fb_fill_ctrl;

    localparam int W = 40;
    localparam int H = 30;
    localparam int S = 8;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        paint_req;
    logic [10:0] paint_x;
    logic [10:0] paint_y;
    logic [7:0]  paint_r;
    logic [7:0]  paint_g;
    logic [7:0]  paint_b;
    logic        ready;
    logic        done;
    logic        write_enable;
    logic [10:0] data_in_x;
    logic [10:0] data_in_y;
    logic [7:0]  red_data_in;
    logic [7:0]  green_data_in;
    logic [7:0]  blue_data_in;

    fb_fill_ctrl #(.W_RES(W), .H_RES(H), .SIZE(S)) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .clear_req     (clear_req),
        .paint_req     (paint_req),
        .paint_x       (paint_x),
        .paint_y       (paint_y),
        .paint_r       (paint_r),
        .paint_g       (paint_g),
        .paint_b       (paint_b),
        .ready         (ready),
        .done          (done),
        .write_enable  (write_enable),
        .data_in_x     (data_in_x),
        .data_in_y     (data_in_y),
        .red_data_in   (red_data_in),
        .green_data_in (green_data_in),
        .blue_data_in  (blue_data_in)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int x;
        int y;
        int r;
        int g;
        int b;
    } pix_t;

    typedef struct {
        bit clr;
        bit pnt;
        int x;
        int y;
        int r;
        int g;
        int b;
        int n;
        int fx;
        int fy;
        int lx;
        int ly;
    } vec_t;

    pix_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected write list straight from the fill rules: whole screen white, or a clipped square.
    function automatic void build(input bit clr, input bit pnt, input int x, input int y,
                                  input int r, input int g, input int b);
        int xe;
        int ye;
        exp_q.delete();
        if (clr) begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++)
                    exp_q.push_back('{xx, yy, 255, 255, 255});
        end else if (pnt && x < W && y < H) begin
            xe = (x + S - 1 < W - 1) ? x + S - 1 : W - 1;
            ye = (y + S - 1 < H - 1) ? y + S - 1 : H - 1;
            for (int yy = y; yy <= ye; yy++)
                for (int xx = x; xx <= xe; xx++)
                    exp_q.push_back('{xx, yy, r, g, b});
        end
    endfunction

    // Called at the negedge just after the accepting edge; consumes the whole write burst.
    task automatic expect_stream(input bit poke, output int cnt, output int fx, output int fy,
                                 output int lx, output int ly);
        int bad;
        bad = 0;
        cnt = 0;
        fx = -1; fy = -1; lx = -1; ly = -1;
        while (write_enable === 1'b1 && cnt < 5000) begin
            if (cnt < exp_q.size()) begin
                if (int'(data_in_x) != exp_q[cnt].x || int'(data_in_y) != exp_q[cnt].y ||
                    int'(red_data_in) != exp_q[cnt].r || int'(green_data_in) != exp_q[cnt].g ||
                    int'(blue_data_in) != exp_q[cnt].b || ready !== 1'b0 || done !== 1'b0)
                    bad++;
            end else begin
                bad++;
            end
            if (cnt == 0) begin
                fx = int'(data_in_x);
                fy = int'(data_in_y);
            end
            lx = int'(data_in_x);
            ly = int'(data_in_y);
            if (poke && cnt == 1) begin
                paint_req = 1'b1;
                paint_x   = 11'd0;
                paint_y   = 11'd0;
            end else if (poke && cnt == 2) begin
                paint_req = 1'b0;
            end
            cnt++;
            @(negedge CLOCK_50);
        end
        paint_req = 1'b0;
        check("stream_pixels_bad", bad, 0);
        check("stream_count", cnt, exp_q.size());
        check("done_pulse we/done/ready", {write_enable, done, ready}, 3'b010);
        if (exp_q.size() > 0)
            check("hold_coords", {data_in_x, data_in_y},
                  {11'(exp_q[exp_q.size()-1].x), 11'(exp_q[exp_q.size()-1].y)});
        @(negedge CLOCK_50);
        check("back_to_idle we/done/ready", {write_enable, done, ready}, 3'b001);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 3000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ready_wait", ready, 1'b1);
    endtask

    task automatic do_op(input bit clr, input bit pnt, input int x, input int y, input int r,
                         input int g, input int b, input bit poke, output int cnt,
                         output int fx, output int fy, output int lx, output int ly);
        wait_ready();
        build(clr, pnt, x, y, r, g, b);
        clear_req = clr;
        paint_req = pnt;
        paint_x   = 11'(x);
        paint_y   = 11'(y);
        paint_r   = 8'(r);
        paint_g   = 8'(g);
        paint_b   = 8'(b);
        @(negedge CLOCK_50);
        // Scramble the request inputs: the operation must run from the latched copy.
        clear_req = 1'b0;
        paint_req = 1'b0;
        paint_x   = ~11'(x);
        paint_y   = ~11'(y);
        paint_r   = ~8'(r);
        paint_g   = ~8'(g);
        paint_b   = ~8'(b);
        expect_stream(poke, cnt, fx, fy, lx, ly);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int cnt, fx, fy, lx, ly, n, t;
        bit clr, pnt, poke;

        vecs[0] = '{0, 1, 10, 5, 255, 0, 0, 64, 10, 5, 17, 12};
        vecs[1] = '{0, 1, 36, 26, 0, 255, 0, 16, 36, 26, 39, 29};
        vecs[2] = '{0, 1, 40, 10, 1, 2, 3, 0, -1, -1, -1, -1};
        vecs[3] = '{0, 1, 5, 30, 9, 9, 9, 0, -1, -1, -1, -1};
        vecs[4] = '{1, 1, 3, 3, 0, 0, 0, 1200, 0, 0, 39, 29};
        vecs[5] = '{0, 1, 0, 0, 1, 2, 3, 64, 0, 0, 7, 7};
        vecs[6] = '{0, 1, 39, 0, 7, 7, 7, 8, 39, 0, 39, 7};
        vecs[7] = '{0, 1, 33, 22, 100, 150, 200, 56, 33, 22, 39, 29};

        clear_req = 1'b0;
        paint_req = 1'b0;
        paint_x = '0; paint_y = '0;
        paint_r = '0; paint_g = '0; paint_b = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset_outputs",
              {ready, done, write_enable, data_in_x, data_in_y, red_data_in, green_data_in,
               blue_data_in}, 64'd0);

        // Power-on clear starts on the first edge after release.
        reset = 1'b1;
        build(1, 0, 0, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        check("boot_first_write", {write_enable, data_in_x, data_in_y}, {1'b1, 11'd0, 11'd0});
        expect_stream(0, cnt, fx, fy, lx, ly);
        check("boot_last", {lx[10:0], ly[10:0]}, {11'd39, 11'd29});

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].clr, vecs[i].pnt, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g,
                  vecs[i].b, (i == 0 || i == 7), cnt, fx, fy, lx, ly);
            check($sformatf("vec%0d_count", i), cnt, vecs[i].n);
            check($sformatf("vec%0d_first", i), {fx, fy}, {vecs[i].fx, vecs[i].fy});
            check($sformatf("vec%0d_last", i), {lx, ly}, {vecs[i].lx, vecs[i].ly});
        end

        for (int i = 0; i < 25; i++) begin
            t    = $urandom_range(0, 9);
            clr  = (t <= 1);
            pnt  = (t != 0);
            poke = 1'($urandom_range(0, 1));
            do_op(clr, pnt, $urandom_range(0, W + 4), $urandom_range(0, H + 4),
                  $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  poke, cnt, fx, fy, lx, ly);
        end

        // Reset dropped in the middle of a clear, off the clock edge.
        wait_ready();
        clear_req = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        cnt = 0;
        n = 0;
        while (cnt < 1000 && n < 1200) begin
            if (write_enable) cnt++;
            n++;
            @(negedge CLOCK_50);
        end
        check("mid_clear_write1000", {write_enable, data_in_x, data_in_y},
              {1'b1, 11'd0, 11'd25});
        #2 reset = 1'b0;
        #1;
        check("async_abort", {write_enable, done, ready, data_in_x, data_in_y}, 64'd0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("held_in_reset", {write_enable, done, ready}, 3'b000);
        reset = 1'b1;
        build(1, 0, 0, 0, 0, 0, 0);
        @(negedge CLOCK_50);
        check("restart_at_origin", {write_enable, data_in_x, data_in_y}, {1'b1, 11'd0, 11'd0});
        expect_stream(0, cnt, fx, fy, lx, ly);

        repeat (3) @(negedge CLOCK_50);
        check("idle_quiet", {write_enable, done, ready}, 3'b001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
